// File: rtl/sdt_pkg.sv
// Shared types and limits for the SDT memory target.
package sdt_pkg;

    localparam int MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } sdt_slv_state_e;

    typedef enum logic {
        READ,
        WRITE
    } sdt_op_e;

endpackage

// File: rtl/sdt_mem_array.sv
// Flop-based word storage with async reset to RESET_VALUE,
// one synchronous write port and one combinational read port.
module sdt_mem_array #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdt_mem_slave.sv
// SDT memory target: accepts rd/wr requests, acks after LATENCY cycles,
// returns read data in the ack cycle and flags protocol misuse.
module sdt_mem_slave
    import sdt_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    LATENCY     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ack,
    output logic                  busy,
    output logic                  err_proto
);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_latency_check
            $error("sdt_mem_slave: LATENCY must lie in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    sdt_slv_state_e        state_q,    state_d;
    sdt_op_e               op_q,       op_d;
    logic [3:0]            cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic                  ack_q,      ack_d;
    logic                  busy_q,     busy_d;
    logic                  err_q,      err_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] read_word;

    sdt_mem_array #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (cap_addr_q),
        .wdata (cap_data_q),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Storage is committed at the edge that ends the ACK cycle of a write.
    assign mem_we = (state_q == ACK) && (op_q == WRITE);

    // With LATENCY=1 the read data is loaded on the accepting edge, so the
    // live address has to drive the read port while idle.
    assign mem_raddr = (state_q == IDLE) ? addr : cap_addr_q;
    assign read_word = (mem_we && (cap_addr_q == mem_raddr)) ? cap_data_q : mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= READ;
            cnt_q      <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            rd_data_q  <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            rd_data_q  <= rd_data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        rd_data_d  = '0;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (rd || wr) begin
                    cap_addr_d = addr;
                    cap_data_d = wr_data;
                    op_d       = wr ? WRITE : READ;
                    busy_d     = 1'b1;
                    if (rd && wr) begin
                        err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        if (!wr) begin
                            rd_data_d = read_word;
                        end
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!rd && !wr) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (op_q == READ) begin
                        rd_data_d = read_word;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign rd_data   = rd_data_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign err_proto = err_q;

endmodule

// File: tb/tb_sdt_mem_slave.sv
// Directed bench for sdt_mem_slave: instance 0 uses LATENCY=2, instance 1 LATENCY=1.
module tb_sdt_mem_slave;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    logic       clk;
    logic [1:0] rst_v, rd_v, wr_v, ack_v, busy_v, err_v;
    logic [7:0] addr_v [2];
    logic [7:0] wd_v   [2];
    logic [7:0] rdd_v  [2];

    int cyc;
    int n_tests;
    int n_fail;

    sdt_mem_slave #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .LATENCY     (2),
        .RESET_VALUE (8'h00)
    ) u_dut_l2 (
        .clk       (clk),
        .rst       (rst_v[0]),
        .rd        (rd_v[0]),
        .wr        (wr_v[0]),
        .addr      (addr_v[0]),
        .wr_data   (wd_v[0]),
        .rd_data   (rdd_v[0]),
        .ack       (ack_v[0]),
        .busy      (busy_v[0]),
        .err_proto (err_v[0])
    );

    sdt_mem_slave #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .LATENCY     (1),
        .RESET_VALUE (8'h00)
    ) u_dut_l1 (
        .clk       (clk),
        .rst       (rst_v[1]),
        .rd        (rd_v[1]),
        .wr        (wr_v[1]),
        .addr      (addr_v[1]),
        .wr_data   (wd_v[1]),
        .rd_data   (rdd_v[1]),
        .ack       (ack_v[1]),
        .busy      (busy_v[1]),
        .err_proto (err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: plain; 1: switch addr to alt_addr after one cycle; 2: drop request after one cycle
    task automatic xfer(input int d, input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] wd, input int mode, input logic [7:0] alt_addr,
                        output int lat, output int ack_cyc, output logic [7:0] rdat,
                        output logic errv);
        int  start;
        bit  got;
        @(negedge clk);
        rd_v[d]   = r;
        wr_v[d]   = w;
        addr_v[d] = a;
        wd_v[d]   = wd;
        start     = cyc;
        got       = 0;
        lat       = -1;
        ack_cyc   = -1;
        rdat      = 8'hxx;
        errv      = 1'bx;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ack_v[d]) begin
                got     = 1;
                lat     = cyc - start;
                ack_cyc = cyc;
                rdat    = rdd_v[d];
                errv    = err_v[d];
            end else if (k == 0 && mode == 1) begin
                addr_v[d] = alt_addr;
            end else if (k == 0 && mode == 2) begin
                rd_v[d] = 1'b0;
                wr_v[d] = 1'b0;
            end
        end
        rd_v[d] = 1'b0;
        wr_v[d] = 1'b0;
    endtask

    vec_t       vecs [9];
    int         lat, ack_c, prev_ack_c;
    logic [7:0] rdat;
    logic       errv;
    logic       saw_ack;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_v   = 2'b00;
        rd_v    = 2'b00;
        wr_v    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = 8'h00;
            wd_v[i]   = 8'h00;
        end

        vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h02, 8'h22, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_ack",   32'(ack_v[0]),  32'h0);
        check("reset_busy",  32'(busy_v[0]), 32'h0);
        check("reset_err",   32'(err_v[0]),  32'h0);
        check("reset_rdata", 32'(rdd_v[0]),  32'h0);
        rst_v = 2'b11;
        @(negedge clk);

        // Table: back-to-back transfers on the LATENCY=2 instance
        prev_ack_c = -1;
        for (int i = 0; i < 9; i++) begin
            xfer(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 8'h00,
                 lat, ack_c, rdat, errv);
            check($sformatf("vec%0d_lat", i),   32'(lat),  32'd2);
            check($sformatf("vec%0d_rdata", i), 32'(rdat), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i),   32'(errv), 32'(vecs[i].exp_err));
            if (i == 2) check("b2b_ack_spacing", 32'(ack_c - prev_ack_c), 32'd3);
            prev_ack_c = ack_c;
        end

        // Address changed after acceptance is ignored
        xfer(0, 1'b1, 1'b0, 8'h01, 8'h00, 1, 8'h02, lat, ack_c, rdat, errv);
        check("addr_chg_rdata", 32'(rdat), 32'h11);
        check("addr_chg_err",   32'(errv), 32'h0);

        // Request dropped in WAIT still completes, flags error
        xfer(0, 1'b1, 1'b0, 8'h3C, 8'h00, 2, 8'h00, lat, ack_c, rdat, errv);
        check("drop_lat",   32'(lat),  32'd2);
        check("drop_rdata", 32'(rdat), 32'hA5);
        check("drop_err",   32'(errv), 32'h1);

        // Reset clears the sticky flag and storage
        @(negedge clk);
        rst_v[0] = 1'b0;
        #1;
        check("rst_err_clr", 32'(err_v[0]), 32'h0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        xfer(0, 1'b1, 1'b0, 8'h3C, 8'h00, 0, 8'h00, lat, ack_c, rdat, errv);
        check("rst_mem_clr", 32'(rdat), 32'h00);

        // rd and wr together: performed as write, sticky error
        xfer(0, 1'b1, 1'b1, 8'h07, 8'h33, 0, 8'h00, lat, ack_c, rdat, errv);
        check("rdwr_lat",   32'(lat),  32'd2);
        check("rdwr_rdata", 32'(rdat), 32'h00);
        check("rdwr_err",   32'(errv), 32'h1);
        xfer(0, 1'b1, 1'b0, 8'h07, 8'h00, 0, 8'h00, lat, ack_c, rdat, errv);
        check("rdwr_readback",  32'(rdat), 32'h33);
        check("rdwr_err_stays", 32'(errv), 32'h1);

        // Reset in the WAIT cycle of a write aborts it
        @(negedge clk);
        wr_v[0]   = 1'b1;
        addr_v[0] = 8'h20;
        wd_v[0]   = 8'h99;
        @(negedge clk);
        check("abort_busy_wait", 32'(busy_v[0]), 32'h1);
        rst_v[0] = 1'b0;
        #1;
        check("abort_busy_clr", 32'(busy_v[0]), 32'h0);
        check("abort_ack_clr",  32'(ack_v[0]),  32'h0);
        wr_v[0] = 1'b0;
        saw_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_ack = saw_ack | ack_v[0];
        end
        rst_v[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            saw_ack = saw_ack | ack_v[0];
        end
        check("abort_no_ack", 32'(saw_ack), 32'h0);
        xfer(0, 1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h00, lat, ack_c, rdat, errv);
        check("abort_no_write", 32'(rdat), 32'h00);
        check("abort_err",      32'(errv), 32'h0);

        // LATENCY=1 instance
        xfer(1, 1'b0, 1'b1, 8'hFF, 8'h5A, 0, 8'h00, lat, ack_c, rdat, errv);
        check("l1_wr_lat", 32'(lat), 32'd1);
        prev_ack_c = ack_c;
        xfer(1, 1'b1, 1'b0, 8'hFF, 8'h00, 0, 8'h00, lat, ack_c, rdat, errv);
        check("l1_rd_lat",     32'(lat),  32'd1);
        check("l1_rd_rdata",   32'(rdat), 32'h5A);
        check("l1_ack_spacing", 32'(ack_c - prev_ack_c), 32'd2);
        @(negedge clk);
        check("l1_post_ack",   32'(ack_v[1]),  32'h0);
        check("l1_post_rdata", 32'(rdd_v[1]),  32'h0);
        check("l1_post_busy",  32'(busy_v[1]), 32'h0);
        xfer(1, 1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h00, lat, ack_c, rdat, errv);
        check("l1_rd0_rdata", 32'(rdat), 32'h00);
        check("l1_err",       32'(errv), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdt_mem_slave.md
Name: sdt_mem_slave

Overview:
- Synthesizable SDT memory target: the block directly downstream of an SDT master port, answering rd/wr requests.
- Replaces the dummy SDT endpoint in B2B and integration benches so the arbiter sees real read-back data and ack timing.
- Provides flop-based storage, a programmable ack latency, a busy indication and a sticky protocol-error flag.

Parameters:
- ADDR_WIDTH, 8, address bus width; storage depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, data word width.
- LATENCY, 2, number of cycles from the first request cycle to the ack cycle; legal range 1..15.
- RESET_VALUE, 0, value loaded into every storage word on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it (0) clears state immediately; deassertion is synchronised externally.
- rd  input  1  read request; held high by the master until ack.
- wr  input  1  write request; held high by the master until ack.
- addr  input  ADDR_WIDTH  word address; sampled at request acceptance.
- wr_data  input  DATA_WIDTH  write data; sampled at request acceptance.
- rd_data  output  DATA_WIDTH  read data; valid only in the ack cycle of a read, 0 otherwise.
- ack  output  1  single-cycle completion pulse.
- busy  output  1  high from acceptance until the ack cycle inclusive.
- err_proto  output  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (rst=0): state=IDLE, ack=0, rd_data=0, busy=0, err_proto=0, latency counter=0, all storage words=RESET_VALUE.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On a rising edge with rd|wr=1: capture addr, wr_data and op (op=WRITE if wr else READ); busy<=1.
  - If LATENCY=1, go to ACK; otherwise go to WAIT with counter=LATENCY-2.
- WAIT: counter decrements each cycle; at counter=0, go to ACK.
- ACK (one cycle):
  - ack=1.
  - Write: the captured word is written into storage at the edge ending this cycle. rd_data=0.
  - Read: rd_data = storage[captured addr], with pending write data visible in the same cycle.
  - Next state is always IDLE; busy<=0 at the exiting edge.
- Timing:
  - If the request is first high in cycle 0, ack is high in cycle LATENCY.
  - Back-to-back throughput is one transfer per LATENCY+1 cycles.
  - In the cycle after ACK the FSM is in IDLE and may accept a new request.
  - The still-high old request seen at the ACK-exit edge is ignored.
- addr/wr_data changes after acceptance: ignored; the captured values are used.
- rd=1 and wr=1 at acceptance: performed as a write; err_proto<=1.
- Request dropped (rd=wr=0) in WAIT: the transaction still completes with ack; err_proto<=1.
- Address wrap: no boundary effects; the full 2**ADDR_WIDTH range is addressable.
- Reset mid-transaction: the transfer is aborted with no ack and no write. Storage returns to RESET_VALUE.
- Width rules: no arithmetic on the data path. The counter is 4 bits; LATENCY outside 1..15 is rejected by an elaboration-time assertion.

Decomposition:
- Package sdt_pkg holds:
  - state enum sdt_slv_state_e {IDLE, WAIT, ACK};
  - op enum sdt_op_e {READ, WRITE};
  - localparam MAX_LATENCY=15.
- Sub-module sdt_mem_array:
  - async-reset flop array with RESET_VALUE;
  - one write port (we, waddr, wdata) and one combinational read port (raddr -> rdata);
  - instantiated once in sdt_mem_slave.
- sdt_mem_slave contains the FSM, capture registers, counter, output registers and err_proto.

Test Plan:
- Reset with defaults, then read addr 0x10 -> ack in cycle 2 after request, rd_data=0x00, err_proto=0.
- Write 0xA5 to 0x3C, then read 0x3C back-to-back -> first ack at cycle 2, second ack at cycle 5, rd_data=0xA5 in that cycle only.
- LATENCY=1: write 0x5A to 0xFF then read 0xFF -> acks at cycles 1 and 3, rd_data=0x5A; read of 0x00 returns 0x00.
- rd=wr=1 with addr 0x07, wr_data 0x33 -> single ack, err_proto=1 and stays 1; a later read of 0x07 returns 0x33.
- Change addr from 0x01 to 0x02 one cycle after the request, with 0x01=0x11 and 0x02=0x22 preloaded -> rd_data=0x11.
- Assert rst=0 in the WAIT cycle of a write of 0x99 to 0x20 -> ack never pulses, busy=0 immediately, a later read of 0x20 returns 0x00.
